// File: rtl/stdp_pkg.sv
// Shared parameters and encodings for the STDP update scheduler.
package stdp_pkg;
   localparam int NUM_PRE = 4;
   localparam int TW      = 4;
   localparam int WINDOW  = 8;
   localparam int TMAX    = (1 << TW) - 1;

   typedef enum logic {DIR_LTD = 1'b0, DIR_LTP = 1'b1} dir_e;
   typedef enum logic {S_IDLE = 1'b0, S_PRESENT = 1'b1} state_e;
endpackage

// File: rtl/stdp_rr_arbiter.sv
// Round-robin grant over NUM_PRE request slots; pointer moves past the accepted index.
module stdp_rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          accept,
   input  logic [IW-1:0] acc_idx,
   output logic          gnt_vld,
   output logic [IW-1:0] gnt_idx
);
   import stdp_pkg::*;

   logic [IW-1:0] ptr;
   logic [IW-1:0] base;

   // On accept the search already starts past the slot being retired, so a
   // back-to-back grant needs no bubble.
   always_comb begin
      base    = accept ? IW'((int'(acc_idx) + 1) % N) : ptr;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < N; k++) begin
         if (!gnt_vld && req[(int'(base) + k) % N]) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'((int'(base) + k) % N);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)      ptr <= '0;
      else if (accept) ptr <= base;
   end
endmodule

// File: rtl/stdp_update_scheduler.sv
// Spike timers, per-neuron request slots and a two-state presenter feeding a
// weight-update unit with LTP/LTD requests.
module stdp_update_scheduler #(
   parameter  int NUM_PRE = stdp_pkg::NUM_PRE,
   parameter  int TW      = stdp_pkg::TW,
   parameter  int WINDOW  = stdp_pkg::WINDOW,
   localparam int IW      = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NUM_PRE-1:0] pre_spike,
   input  logic               post_spike,
   input  logic               upd_ready,
   input  logic               clr_ovf,
   output logic               upd_valid,
   output logic [IW-1:0]      upd_idx,
   output logic               upd_dir,
   output logic [TW-1:0]      upd_dt,
   output logic [NUM_PRE-1:0] pending,
   output logic               ovf
);
   import stdp_pkg::*;

   localparam logic [TW-1:0] TSAT = '1;

   logic [NUM_PRE-1:0][TW-1:0] pre_tmr;
   logic [TW-1:0]              post_tmr;
   logic [NUM_PRE-1:0]         slot_vld, slot_dir;
   logic [NUM_PRE-1:0][TW-1:0] slot_dt;
   logic [NUM_PRE-1:0]         ltp, ltd, clr, drop, presented, req;
   state_e                     state;
   logic                       hs, gnt_vld;
   logic [IW-1:0]              gnt_idx;

   assign hs      = upd_valid & upd_ready;
   assign pending = slot_vld;

   // A coincident pre/post spike counts as causal with dt=0, never as LTD.
   always_comb begin
      for (int i = 0; i < NUM_PRE; i++) begin
         ltp[i]       = en & post_spike & (pre_spike[i] | (int'(pre_tmr[i]) < WINDOW));
         ltd[i]       = en & pre_spike[i] & ~post_spike & (int'(post_tmr) < WINDOW);
         presented[i] = (state == S_PRESENT) && (upd_idx == IW'(i));
         clr[i]       = hs && (upd_idx == IW'(i));
         drop[i]      = (ltp[i] | ltd[i]) & slot_vld[i] & ~clr[i];
         req[i]       = en & slot_vld[i] & ~clr[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                post_tmr <= TSAT;
      else if (post_spike)       post_tmr <= TW'(1);
      else if (post_tmr != TSAT) post_tmr <= post_tmr + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_tmr  <= {NUM_PRE{TSAT}};
         slot_vld <= '0;
         slot_dir <= '0;
         slot_dt  <= '0;
      end else begin
         for (int i = 0; i < NUM_PRE; i++) begin
            if (pre_spike[i])              pre_tmr[i] <= TW'(1);
            else if (pre_tmr[i] != TSAT)   pre_tmr[i] <= pre_tmr[i] + 1'b1;

            if (!en)
               slot_vld[i] <= presented[i] & ~clr[i];
            else if ((ltp[i] | ltd[i]) && (!slot_vld[i] || clr[i])) begin
               slot_vld[i] <= 1'b1;
               slot_dir[i] <= ltp[i] ? DIR_LTP : DIR_LTD;
               slot_dt[i]  <= ltp[i] ? (pre_spike[i] ? '0 : pre_tmr[i]) : post_tmr;
            end else if (clr[i])
               slot_vld[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)        ovf <= 1'b0;
      else if (|drop)    ovf <= 1'b1;
      else if (clr_ovf)  ovf <= 1'b0;
   end

   stdp_rr_arbiter #(.N(NUM_PRE), .IW(IW)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .accept  (hs),
      .acc_idx (upd_idx),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         upd_valid <= 1'b0;
         upd_idx   <= '0;
         upd_dir   <= 1'b0;
         upd_dt    <= '0;
      end else begin
         case (state)
            S_IDLE:
               if (gnt_vld) begin
                  state     <= S_PRESENT;
                  upd_valid <= 1'b1;
                  upd_idx   <= gnt_idx;
                  upd_dir   <= slot_dir[gnt_idx];
                  upd_dt    <= slot_dt[gnt_idx];
               end
            S_PRESENT:
               if (hs) begin
                  if (gnt_vld) begin
                     upd_idx <= gnt_idx;
                     upd_dir <= slot_dir[gnt_idx];
                     upd_dt  <= slot_dt[gnt_idx];
                  end else begin
                     state     <= S_IDLE;
                     upd_valid <= 1'b0;
                  end
               end
         endcase
      end
   end
endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Directed vectors plus hand-written sequences for the STDP update scheduler.
module tb_stdp_update_scheduler;
   logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, post_spike = 1'b0;
   logic       upd_ready = 1'b0, clr_ovf = 1'b0;
   logic [3:0] pre_spike = '0;
   logic       upd_valid, upd_dir, ovf;
   logic [1:0] upd_idx;
   logic [3:0] upd_dt, pending;

   int total = 0, bad = 0, hs_cnt = 0, h0;

   typedef struct { int idx; int gap; bit ev; bit dir; int dt; } vec_t;
   vec_t tv[10];

   stdp_update_scheduler dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pre_spike(pre_spike),
      .post_spike(post_spike), .upd_ready(upd_ready), .clr_ovf(clr_ovf),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_dir(upd_dir),
      .upd_dt(upd_dt), .pending(pending), .ovf(ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rst_n && upd_valid && upd_ready) hs_cnt++;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; pre_spike = '0; post_spike = 1'b0;
      upd_ready = 1'b0; en = 1'b1; clr_ovf = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   initial begin
      // gap = post edge - pre edge; negative means post first
      tv[0] = '{0,   3, 1'b1, 1'b1, 3};
      tv[1] = '{1,   7, 1'b1, 1'b1, 7};
      tv[2] = '{2,   8, 1'b0, 1'b0, 0};
      tv[3] = '{3,   1, 1'b1, 1'b1, 1};
      tv[4] = '{2,  -3, 1'b1, 1'b0, 3};
      tv[5] = '{1,  -7, 1'b1, 1'b0, 7};
      tv[6] = '{0,  -8, 1'b0, 1'b0, 0};
      tv[7] = '{3,   0, 1'b1, 1'b1, 0};
      tv[8] = '{1, -10, 1'b0, 1'b0, 0};
      tv[9] = '{2,  20, 1'b0, 1'b0, 0};

      do_reset();
      chk("rst_valid", upd_valid, 0);
      chk("rst_idx", upd_idx, 0);
      chk("rst_dir", upd_dir, 0);
      chk("rst_dt", upd_dt, 0);
      chk("rst_pending", pending, 0);
      chk("rst_ovf", ovf, 0);

      for (int v = 0; v < 10; v++) begin
         int g, a;
         do_reset();
         g = tv[v].gap;
         a = (g < 0) ? -g : g;
         pre_spike  = (g >= 0) ? 4'(1 << tv[v].idx) : 4'b0;
         post_spike = (g <= 0);
         tick();
         pre_spike = '0; post_spike = 1'b0;
         if (a > 0) begin
            repeat (a - 1) tick();
            if (g > 0) post_spike = 1'b1;
            else       pre_spike  = 4'(1 << tv[v].idx);
            tick();
            pre_spike = '0; post_spike = 1'b0;
         end
         chk($sformatf("v%0d_pending", v), pending, tv[v].ev ? (1 << tv[v].idx) : 0);
         chk($sformatf("v%0d_early_valid", v), upd_valid, 0);
         tick();
         chk($sformatf("v%0d_valid", v), upd_valid, int'(tv[v].ev));
         if (tv[v].ev) begin
            chk($sformatf("v%0d_idx", v), upd_idx, tv[v].idx);
            chk($sformatf("v%0d_dir", v), upd_dir, int'(tv[v].dir));
            chk($sformatf("v%0d_dt", v), upd_dt, tv[v].dt);
         end
         upd_ready = 1'b1;
         tick();
         upd_ready = 1'b0;
         chk($sformatf("v%0d_done_valid", v), upd_valid, 0);
         chk($sformatf("v%0d_done_pending", v), pending, 0);
      end

      // all four pre, post two edges later: back-to-back round-robin grants
      do_reset();
      pre_spike = 4'b1111; tick(); pre_spike = '0;
      tick();
      post_spike = 1'b1; tick(); post_spike = 1'b0;
      chk("rr_pending", pending, 15);
      upd_ready = 1'b1;
      h0 = hs_cnt;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("rr%0d_valid", k), upd_valid, 1);
         chk($sformatf("rr%0d_idx", k), upd_idx, k);
         chk($sformatf("rr%0d_dir", k), upd_dir, 1);
         chk($sformatf("rr%0d_dt", k), upd_dt, 2);
      end
      tick();
      upd_ready = 1'b0;
      chk("rr_end_valid", upd_valid, 0);
      chk("rr_handshakes", hs_cnt - h0, 4);

      // backpressure hold, dropped LTD, ovf held against a same-edge clear
      do_reset();
      post_spike = 1'b1; tick(); post_spike = 1'b0;
      pre_spike = 4'b0001; tick(); pre_spike = '0;
      tick();
      h0 = hs_cnt;
      for (int k = 0; k < 5; k++) begin
         if (k < 2) pre_spike = 4'b0001;
         clr_ovf = (k == 1);
         tick();
         pre_spike = '0; clr_ovf = 1'b0;
         chk($sformatf("hold%0d_valid", k), upd_valid, 1);
         chk($sformatf("hold%0d_idx", k), upd_idx, 0);
         chk($sformatf("hold%0d_dir", k), upd_dir, 0);
         chk($sformatf("hold%0d_dt", k), upd_dt, 1);
         chk($sformatf("hold%0d_ovf", k), ovf, 1);
      end
      upd_ready = 1'b1; tick(); upd_ready = 1'b0;
      tick(); tick();
      chk("drop_handshakes", hs_cnt - h0, 1);
      chk("drop_valid", upd_valid, 0);
      chk("drop_pending", pending, 0);
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      chk("clr_ovf", ovf, 0);

      // request landing on its own slot's handshake edge reloads without ovf
      do_reset();
      post_spike = 1'b1; tick(); post_spike = 1'b0;
      pre_spike = 4'b0001; tick(); pre_spike = '0;
      tick();
      upd_ready = 1'b1; pre_spike = 4'b0001;
      tick();
      upd_ready = 1'b0; pre_spike = '0;
      chk("reload_ovf", ovf, 0);
      chk("reload_pending", pending, 1);
      tick();
      chk("reload_valid", upd_valid, 1);
      chk("reload_dt", upd_dt, 3);
      chk("reload_dir", upd_dir, 0);

      // coincident pre[3] and post: LTP dt=0 only, even with post timer in window
      do_reset();
      post_spike = 1'b1; tick(); post_spike = 1'b0;
      tick();
      pre_spike = 4'b1000; post_spike = 1'b1; tick();
      pre_spike = '0; post_spike = 1'b0;
      chk("same_pending", pending, 8);
      tick();
      chk("same_idx", upd_idx, 3);
      chk("same_dir", upd_dir, 1);
      chk("same_dt", upd_dt, 0);
      h0 = hs_cnt;
      upd_ready = 1'b1; tick(); tick(); upd_ready = 1'b0;
      chk("same_handshakes", hs_cnt - h0, 1);
      chk("same_ovf", ovf, 0);

      // en=0 flushes unpresented slots; presented one waits for its handshake
      do_reset();
      pre_spike = 4'b0011; tick(); pre_spike = '0;
      post_spike = 1'b1; tick(); post_spike = 1'b0;
      tick();
      en = 1'b0; tick();
      chk("en0_pending", pending, 1);
      chk("en0_valid", upd_valid, 1);
      upd_ready = 1'b1; tick(); upd_ready = 1'b0;
      chk("en0_done_valid", upd_valid, 0);
      chk("en0_done_pending", pending, 0);
      en = 1'b1;

      // reset while presenting aborts the request
      do_reset();
      post_spike = 1'b1; tick(); post_spike = 1'b0;
      pre_spike = 4'b0001; tick(); pre_spike = '0;
      tick();
      chk("abort_pre_valid", upd_valid, 1);
      rst_n = 1'b0; tick();
      chk("abort_valid", upd_valid, 0);
      chk("abort_pending", pending, 0);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
